// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants and memory-stage FSM state encoding.
package cpu_pkg;

  localparam logic [2:0] OP_LOAD_DEF  = 3'b101;
  localparam logic [2:0] OP_STORE_DEF = 3'b100;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

// File: rtl/memory_access.sv
// Memory pipeline stage: issues load/store requests to data memory, stalls
// upstream until the access completes and forwards results to writeback.
module memory_access
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_INSTR = 16'h0000,
  parameter logic [2:0]  OP_LOAD     = OP_LOAD_DEF,
  parameter logic [2:0]  OP_STORE    = OP_STORE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bubble_in,
  input  logic        halt_in_wb,
  input  logic [15:0] instr_in,
  input  logic [15:0] result_in,
  input  logic [15:0] store_data_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic [15:0] wb_result_out,
  output logic [15:0] instr_out,
  output logic        bubble_out,
  output logic        load_pending
);

  logic [0:0]  state_reg;
  logic        we_reg;
  logic        load_reg;
  logic        halt_seen_reg;
  logic [15:0] addr_reg;
  logic [15:0] wdata_reg;
  logic        bubble_reg;
  logic [15:0] instr_reg;
  logic [15:0] wb_result_reg;

  logic [2:0] opcode;
  logic       is_load;
  logic       is_store;
  logic       valid_op;

  assign opcode   = instr_in[15:13];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign valid_op = !bubble_in && !halt_in_wb && (is_load || is_store);

  // In WAIT the request is replayed from captured copies so it stays stable
  // even if the upstream operands glitch.
  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = result_in;
    dmem_wdata = store_data_in;
    stall_out  = 1'b0;
    if (!rst) begin
      if (state_reg == ST_WAIT) begin
        dmem_req   = 1'b1;
        dmem_we    = we_reg;
        dmem_addr  = addr_reg;
        dmem_wdata = wdata_reg;
        stall_out  = !dmem_ack;
      end else if (valid_op) begin
        dmem_req   = 1'b1;
        dmem_we    = is_store;
        stall_out  = !dmem_ack;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      halt_seen_reg <= 1'b0;
      bubble_reg    <= 1'b1;
      instr_reg     <= RESET_INSTR;
      wb_result_reg <= 16'h0000;
    end else if (stall_out) begin
      bubble_reg <= 1'b1;
      if (state_reg == ST_IDLE) begin
        state_reg     <= ST_WAIT;
        we_reg        <= is_store;
        load_reg      <= is_load;
        addr_reg      <= result_in;
        wdata_reg     <= store_data_in;
        halt_seen_reg <= 1'b0;
      end else begin
        halt_seen_reg <= halt_seen_reg || halt_in_wb;
      end
    end else if (state_reg == ST_WAIT) begin
      // Ack of an outstanding access; a halt seen at any point discards it.
      state_reg     <= ST_IDLE;
      halt_seen_reg <= 1'b0;
      if (halt_seen_reg || halt_in_wb) begin
        bubble_reg <= 1'b1;
      end else begin
        bubble_reg    <= 1'b0;
        instr_reg     <= instr_in;
        wb_result_reg <= load_reg ? dmem_rdata : addr_reg;
      end
    end else if (bubble_in || halt_in_wb) begin
      bubble_reg <= 1'b1;
    end else begin
      bubble_reg    <= 1'b0;
      instr_reg     <= instr_in;
      wb_result_reg <= is_load ? dmem_rdata : result_in;
    end
  end

  assign bubble_out    = bubble_reg;
  assign instr_out     = instr_reg;
  assign wb_result_out = wb_result_reg;
  assign load_pending  = !bubble_reg && (instr_reg[15:13] == OP_LOAD);

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed vector table, multi-cycle
// corner sequences and randomized transactions against a transaction model.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        bubble_in, halt_in_wb;
  logic [15:0] instr_in, result_in, store_data_in;
  logic        stall_out, dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic [15:0] wb_result_out, instr_out;
  logic        bubble_out, load_pending;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected registered state, maintained per transaction.
  logic        exp_bub;
  logic [15:0] exp_instr, exp_wb;

  memory_access dut (
    .clk(clk), .rst(rst), .bubble_in(bubble_in), .halt_in_wb(halt_in_wb),
    .instr_in(instr_in), .result_in(result_in), .store_data_in(store_data_in),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_result_out(wb_result_out),
    .instr_out(instr_out), .bubble_out(bubble_out), .load_pending(load_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        bub, halt;
    logic [15:0] instr, res, sdata;
    logic        ack;
    logic [15:0] rdata;
    logic        e_req, e_we, e_stall;
    logic [15:0] e_addr, e_wdata;
    logic        e_bub;
    logic [15:0] e_instr, e_wb;
    logic        e_lp;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic b, input logic h, input logic [15:0] i,
                        input logic [15:0] res, input logic [15:0] sd,
                        input logic a, input logic [15:0] rd);
    @(negedge clk);
    rst = r; bubble_in = b; halt_in_wb = h; instr_in = i; result_in = res;
    store_data_in = sd; dmem_ack = a; dmem_rdata = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".bubble_out"}, {15'd0, bubble_out}, {15'd0, exp_bub});
    check({tag, ".instr_out"}, instr_out, exp_instr);
    check({tag, ".wb_result"}, wb_result_out, exp_wb);
    check({tag, ".load_pending"}, {15'd0, load_pending},
          {15'd0, (!exp_bub && exp_instr[15:13] == 3'b101)});
  endtask

  task automatic check_req(input string tag, input logic req, input logic we,
                           input logic [15:0] addr, input logic [15:0] wd, input logic stall);
    check({tag, ".req"}, {15'd0, dmem_req}, {15'd0, req});
    check({tag, ".stall"}, {15'd0, stall_out}, {15'd0, stall});
    if (req) begin
      check({tag, ".we"}, {15'd0, dmem_we}, {15'd0, we});
      check({tag, ".addr"}, dmem_addr, addr);
      if (we) check({tag, ".wdata"}, dmem_wdata, wd);
    end
  endtask

  // One instruction presented until it leaves the stage; n_wait cycles without ack.
  task automatic do_txn(input logic b, input logic h, input logic [15:0] instr,
                        input logic [15:0] res, input logic [15:0] sd,
                        input logic [15:0] rd, input int n_wait);
    logic ld, st, mem;
    ld  = (instr[15:13] == 3'b101);
    st  = (instr[15:13] == 3'b100);
    mem = !b && !h && (ld || st);
    if (!mem) begin
      set_in(0, b, h, instr, res, sd, 1'b0, rd);
      check_req("rnd_pass", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      tick();
      if (b || h) exp_bub = 1'b1;
      else begin exp_bub = 1'b0; exp_instr = instr; exp_wb = res; end
      check_regs("rnd_pass");
    end else begin
      for (int c = 0; c <= n_wait; c++) begin
        set_in(0, 1'b0, 1'b0, instr, res, sd, (c == n_wait), (c == n_wait) ? rd : 16'($urandom));
        check_req("rnd_mem", 1'b1, st, res, sd, (c != n_wait));
        tick();
        if (c < n_wait) exp_bub = 1'b1;
        else begin exp_bub = 1'b0; exp_instr = instr; exp_wb = ld ? rd : res; end
        check_regs("rnd_mem");
      end
    end
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{0,0,16'h2000,16'h1234,16'h0000,0,16'h0000, 0,0,0,16'h0000,16'h0000, 0,16'h2000,16'h1234,0};
    vecs[1] = '{0,0,16'hA040,16'h0040,16'h0000,1,16'hBEEF, 1,0,0,16'h0040,16'h0000, 0,16'hA040,16'hBEEF,1};
    vecs[2] = '{0,0,16'h8123,16'h0055,16'h7777,1,16'h1111, 1,1,0,16'h0055,16'h7777, 0,16'h8123,16'h0055,0};
    vecs[3] = '{1,0,16'hA000,16'h0099,16'h0000,0,16'h0000, 0,0,0,16'h0000,16'h0000, 1,16'h8123,16'h0055,0};
    vecs[4] = '{0,1,16'h8001,16'h0033,16'h4444,0,16'h0000, 0,0,0,16'h0000,16'h0000, 1,16'h8123,16'h0055,0};
    vecs[5] = '{0,0,16'hE00F,16'hFFFF,16'h0000,0,16'h0000, 0,0,0,16'h0000,16'h0000, 0,16'hE00F,16'hFFFF,0};
    vecs[6] = '{0,0,16'h0001,16'h0000,16'h0000,0,16'h0000, 0,0,0,16'h0000,16'h0000, 0,16'h0001,16'h0000,0};

    // Reset with a valid load presented: request and stall must stay low.
    set_in(1, 0, 0, 16'hA000, 16'h0100, 16'h0000, 1'b0, 16'h0000);
    check_req("reset_comb", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    exp_bub = 1'b1; exp_instr = 16'h0000; exp_wb = 16'h0000;
    check_regs("reset");

    foreach (vecs[k]) begin
      set_in(0, vecs[k].bub, vecs[k].halt, vecs[k].instr, vecs[k].res, vecs[k].sdata,
             vecs[k].ack, vecs[k].rdata);
      check_req($sformatf("vec%0d", k), vecs[k].e_req, vecs[k].e_we, vecs[k].e_addr,
                vecs[k].e_wdata, vecs[k].e_stall);
      tick();
      exp_bub = vecs[k].e_bub; exp_instr = vecs[k].e_instr; exp_wb = vecs[k].e_wb;
      check_regs($sformatf("vec%0d", k));
      check($sformatf("vec%0d.lp_table", k), {15'd0, load_pending}, {15'd0, vecs[k].e_lp});
      $display("vector %0d instr=%h wb=%h bubble=%0b", k, instr_in, wb_result_out, bubble_out);
    end

    // Store with three wait cycles, ack on the fourth.
    for (int c = 0; c < 4; c++) begin
      set_in(0, 0, 0, 16'h8010, 16'h0010, 16'h00AA, (c == 3), 16'h5A5A);
      check_req("wait3_store", 1'b1, 1'b1, 16'h0010, 16'h00AA, (c != 3));
      tick();
      if (c < 3) exp_bub = 1'b1;
      else begin exp_bub = 1'b0; exp_instr = 16'h8010; exp_wb = 16'h0010; end
      check_regs("wait3_store");
    end
    $display("sequence wait3_store done instr=%h wb=%h", instr_out, wb_result_out);

    // Halt pulse while a load waits two cycles: held to ack, then discarded.
    for (int c = 0; c < 3; c++) begin
      set_in(0, 0, (c == 1), 16'hA020, 16'h0020, 16'h0000, (c == 2), 16'hCAFE);
      check_req("halt_wait", 1'b1, 1'b0, 16'h0020, 16'h0000, (c != 2));
      tick();
      exp_bub = 1'b1;
      check_regs("halt_wait");
    end
    set_in(0, 1, 0, 16'hA020, 16'h0020, 16'h0000, 1'b0, 16'h0000);
    check_req("halt_after", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    check_regs("halt_after");
    $display("sequence halt_wait done bubble=%0b", bubble_out);

    // Reset in the second wait cycle abandons the request.
    for (int c = 0; c < 2; c++) begin
      set_in(0, 0, 0, 16'hA030, 16'h0030, 16'h0000, 1'b0, 16'h0000);
      check_req("rst_wait", 1'b1, 1'b0, 16'h0030, 16'h0, 1'b1);
      tick();
    end
    set_in(1, 0, 0, 16'hA030, 16'h0030, 16'h0000, 1'b0, 16'h0000);
    check_req("rst_wait_rst", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    exp_bub = 1'b1; exp_instr = 16'h0000; exp_wb = 16'h0000;
    check_regs("rst_wait");
    set_in(0, 1, 0, 16'hA030, 16'h0030, 16'h0000, 1'b0, 16'h0000);
    check_req("rst_idle", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    check_regs("rst_idle");
    // A fresh load must use the new address, proving the FSM is back in IDLE.
    do_txn(0, 0, 16'hA077, 16'h0077, 16'h0000, 16'h1357, 0);
    $display("sequence rst_wait done instr=%h wb=%h", instr_out, wb_result_out);

    // Randomized transactions.
    for (int t = 0; t < 60; t++) begin
      logic [2:0]  op;
      logic        b, h;
      logic [15:0] ins;
      op  = ($urandom_range(0, 1) == 1) ? (($urandom_range(0, 1) == 1) ? 3'b101 : 3'b100)
                                        : 3'($urandom);
      b   = ($urandom_range(0, 7) == 0);
      h   = ($urandom_range(0, 7) == 0);
      ins = {op, 13'($urandom)};
      do_txn(b, h, ins, 16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 3));
      $display("txn %0d instr=%h bub=%0b halt=%0b wb=%h", t, ins, b, h, wb_result_out);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter: RESET_INSTR, 16'h0000, instr_out value loaded on reset.
REQ-002 Parameter: OP_LOAD, 3'b101, opcode (instr[15:13]) treated as a load.
REQ-003 Parameter: OP_STORE, 3'b100, opcode treated as a store.
REQ-004 Clock and reset SHALL be one clock and a synchronous, active-high reset: clk and rst.
REQ-005 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- bubble_in  in  1  upstream (execute) slot empty
- halt_in_wb  in  1  halt committed in writeback; squash
- instr_in  in  16  instruction from execute
- result_in  in  16  ALU result; load/store address
- store_data_in  in  16  store write data
- stall_out  out  1  upstream SHALL hold its registers
- dmem_req  out  1  data-memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  16  word address
- dmem_wdata  out  16  write data
- dmem_ack  in  1  request accepted/completed this cycle
- dmem_rdata  in  16  read data, valid with dmem_ack
- wb_result_out  out  16  value for writeback and forwarding
- instr_out  out  16  instruction to writeback
- bubble_out  out  1  writeback slot empty
- load_pending  out  1  memory-stage slot holds a load (for decode interlock)

Function
REQ-006 Classification: opcode == OP_LOAD -> load; opcode == OP_STORE -> store; all others -> pass-through.
REQ-007 FSM states: IDLE (no outstanding request) and WAIT (request outstanding, not yet acked).
REQ-008 In IDLE, with a valid mem op (!bubble_in && !halt_in_wb && load/store), dmem_req SHALL assert combinationally in the same cycle, with dmem_addr = result_in, dmem_we = store, and dmem_wdata = store_data_in.
REQ-009 IDLE with dmem_ack in the same cycle: zero-wait. stall_out = 0; results register at the next edge; state remains IDLE.
REQ-010 IDLE without dmem_ack: stall_out = 1 combinationally; next state is WAIT.
REQ-011 In WAIT:
- dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL stay constant.
- stall_out = !dmem_ack.
- On ack, return to IDLE at the edge.
REQ-012 On the completing edge:
- load: wb_result_out <= dmem_rdata.
- store: wb_result_out <= result_in.
- pass-through: wb_result_out <= result_in.
- In all cases, instr_out <= instr_in and bubble_out <= 0.
REQ-013 Any edge with stall_out = 1 SHALL load bubble_out <= 1 and leave wb_result_out and instr_out unchanged.
REQ-014 If bubble_in = 1 and no access is outstanding: bubble_out <= 1, no request, stall_out = 0.
REQ-015 halt_in_wb = 1:
- No new request is issued and bubble_out <= 1.
- An outstanding WAIT request is still held until ack, then discarded as a bubble.
REQ-016 dmem_req SHALL never assert for pass-through instructions or bubbles.
REQ-017 load_pending = !bubble_out && instr_out[15:13] == OP_LOAD.
REQ-018 Latency: one cycle for pass-through and zero-wait accesses; 1 + N cycles for N wait cycles.

Reset
REQ-019 With rst high at an edge, the block SHALL enter IDLE with bubble_out = 1, instr_out = RESET_INSTR, and wb_result_out = 0.
REQ-020 While rst is high, dmem_req and stall_out SHALL be forced to 0.
REQ-021 Reset during WAIT abandons the request; the memory SHALL tolerate dmem_req dropping before ack.

Structure
REQ-022 Opcode constants and the state encoding SHALL live in shared package cpu_pkg.
REQ-023 The block SHALL be a single module with no sub-module.

Verification
REQ-024 Pass-through: instr 16'h2000 (op 001), result_in = 16'h1234 -> next edge wb_result_out = 16'h1234, bubble_out = 0, dmem_req never 1.
REQ-025 Zero-wait load: op 101, result_in = 16'h0040, ack same cycle with rdata = 16'hBEEF -> dmem_addr = 16'h0040, stall_out = 0, next edge wb_result_out = 16'hBEEF, load_pending = 1.
REQ-026 Three-wait store: op 100, addr = 16'h0010, data = 16'h00AA, ack on the 4th cycle -> stall_out = 1 for 3 cycles, req/addr/wdata stable, 3 bubbles out, then valid instr_out.
REQ-027 Halt during WAIT: halt_in_wb pulses while a load waits 2 cycles -> request held until ack, bubble_out = 1 throughout, no new req.
REQ-028 Reset in WAIT: rst asserted in the 2nd wait cycle -> next cycle dmem_req = 0, stall_out = 0, bubble_out = 1, state IDLE.
